// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU start/done operand interface: takes commands on a
// valid/ready stream, runs them on the ALU and returns tagged responses.
module alu_cmd_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [7:0]       cmd_a_i,
  input  logic [7:0]       cmd_b_i,
  output logic             alu_start_o,
  output logic [2:0]       alu_op_o,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  input  logic             alu_done_i,
  input  logic [15:0]      alu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [15:0]      rsp_result_o,
  output logic [2:0]       rsp_op_o,
  output logic [7:0]       rsp_latency_o,
  output logic             rsp_timeout_o,
  output logic [CNT_W-1:0] op_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0] TimeoutLat = 8'(TIMEOUT_CYCLES);

  state_t           state_q;
  logic             cmdReady_q;
  logic             aluStart_q;
  logic [2:0]       aluOp_q;
  logic [7:0]       aluA_q;
  logic [7:0]       aluB_q;
  logic [7:0]       runCnt_q;
  logic             rspValid_q;
  logic [15:0]      rspResult_q;
  logic [2:0]       rspOp_q;
  logic [7:0]       rspLatency_q;
  logic             rspTimeout_q;
  logic [CNT_W-1:0] opCount_q;

  logic       cmdFire;
  logic [7:0] runCnt_d;
  logic       watchdogHit;

  // runCnt_d is the number of RUN cycles including the current one, which is
  // both the latency to report on done and the watchdog's elapsed count.
  assign cmdFire     = cmd_valid_i && cmdReady_q;
  assign runCnt_d    = (runCnt_q == 8'hFF) ? 8'hFF : runCnt_q + 8'd1;
  assign watchdogHit = (runCnt_d == TimeoutLat);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmdReady_q   <= 1'b0;
      aluStart_q   <= 1'b0;
      aluOp_q      <= 3'b000;
      aluA_q       <= 8'h00;
      aluB_q       <= 8'h00;
      runCnt_q     <= 8'h00;
      rspValid_q   <= 1'b0;
      rspResult_q  <= 16'h0000;
      rspOp_q      <= 3'b000;
      rspLatency_q <= 8'h00;
      rspTimeout_q <= 1'b0;
      opCount_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmdReady_q <= 1'b1;
          if (cmdFire) begin
            cmdReady_q <= 1'b0;
            aluStart_q <= 1'b1;
            aluOp_q    <= cmd_op_i;
            aluA_q     <= cmd_a_i;
            aluB_q     <= cmd_b_i;
            runCnt_q   <= 8'h00;
            state_q    <= RUN;
          end
        end
        RUN: begin
          runCnt_q <= runCnt_d;
          // Priority order matters: nops never see done, and done beats a
          // watchdog expiry landing on the same cycle.
          if (aluOp_q == 3'b000) begin
            aluStart_q   <= 1'b0;
            rspResult_q  <= 16'h0000;
            rspLatency_q <= 8'd1;
            rspTimeout_q <= 1'b0;
            rspOp_q      <= aluOp_q;
            state_q      <= GAP;
          end else if (alu_done_i) begin
            aluStart_q   <= 1'b0;
            rspResult_q  <= alu_result_i;
            rspLatency_q <= runCnt_d;
            rspTimeout_q <= 1'b0;
            rspOp_q      <= aluOp_q;
            state_q      <= GAP;
          end else if (watchdogHit) begin
            aluStart_q   <= 1'b0;
            rspResult_q  <= 16'h0000;
            rspLatency_q <= TimeoutLat;
            rspTimeout_q <= 1'b1;
            rspOp_q      <= aluOp_q;
            state_q      <= GAP;
          end
        end
        GAP: begin
          rspValid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rspValid_q <= 1'b0;
            opCount_q  <= opCount_q + CNT_W'(1);
            cmdReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmdReady_q;
  assign alu_start_o   = aluStart_q;
  assign alu_op_o      = aluOp_q;
  assign alu_a_o       = aluA_q;
  assign alu_b_o       = aluB_q;
  assign rsp_valid_o   = rspValid_q;
  assign rsp_result_o  = rspResult_q;
  assign rsp_op_o      = rspOp_q;
  assign rsp_latency_o = rspLatency_q;
  assign rsp_timeout_o = rspTimeout_q;
  assign op_count_o    = opCount_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a small behavioural ALU that answers
// single-cycle ops on the first start cycle and multiplies on the fourth.
module tb_alu_cmd_driver;

  localparam int CntW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [7:0]      cmd_a;
  logic [7:0]      cmd_b;
  logic            alu_start;
  logic [2:0]      alu_op;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic            alu_done;
  logic [15:0]     alu_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_result;
  logic [2:0]      rsp_op;
  logic [7:0]      rsp_latency;
  logic            rsp_timeout;
  logic [CntW-1:0] op_count;

  int        assertCount = 0;
  int        failCount   = 0;
  logic [7:0] expCount   = 8'd0;
  logic      noDone      = 1'b0;

  always #5 clk = ~clk;

  // A narrow op counter keeps the wrap-around check short.
  alu_cmd_driver #(.TIMEOUT_CYCLES(16), .CNT_W(CntW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .alu_start_o(alu_start), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_done_i(alu_done), .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_op_o(rsp_op), .rsp_latency_o(rsp_latency), .rsp_timeout_o(rsp_timeout),
    .op_count_o(op_count)
  );

  logic [2:0] startCyc;
  logic [2:0] needCyc;

  always_ff @(posedge clk) begin
    if (!alu_start) startCyc <= 3'd0;
    else if (startCyc != 3'd7) startCyc <= startCyc + 3'd1;
  end

  assign needCyc  = alu_op[2] ? 3'd3 : 3'd0;
  assign alu_done = alu_start && !noDone && (alu_op != 3'b000) && (startCyc == needCyc);

  // Garbage outside done exposes a capture on the wrong cycle.
  always_comb begin
    alu_result = 16'hDEAD;
    if (alu_done) begin
      case (alu_op)
        3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
        3'b010:  alu_result = {8'h00, alu_a & alu_b};
        3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
        default: alu_result = alu_a * alu_b;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expRes, input logic [7:0] expLat,
                               input logic expTo, input int expStarts,
                               input int holdCycles);
    int   guard;
    int   starts;
    logic stableOk;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, ":cmdReady"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput({tag, ":readyDrop"}, cmd_ready, 0);
    starts   = 0;
    stableOk = 1'b1;
    while (alu_start && starts < 300) begin
      stableOk &= (alu_op === op) && (alu_a === a) && (alu_b === b);
      starts++;
      @(negedge clk);
    end
    checkOutput({tag, ":startCycles"}, starts, expStarts);
    checkOutput({tag, ":operandsHeld"}, stableOk, 1);
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, ":rspValid"}, rsp_valid, 1);
    checkOutput({tag, ":result"}, rsp_result, expRes);
    checkOutput({tag, ":op"}, rsp_op, op);
    checkOutput({tag, ":latency"}, rsp_latency, expLat);
    checkOutput({tag, ":timeout"}, rsp_timeout, expTo);
    stableOk = 1'b1;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      stableOk &= (rsp_valid === 1'b1) && (rsp_result === expRes) && (rsp_op === op) &&
                  (rsp_latency === expLat) && (rsp_timeout === expTo) &&
                  (cmd_ready === 1'b0) && (op_count === expCount);
    end
    checkOutput({tag, ":heldWhileStalled"}, stableOk, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    expCount++;
    checkOutput({tag, ":rspDrop"}, rsp_valid, 0);
    checkOutput({tag, ":opCount"}, op_count, expCount);
    checkOutput({tag, ":readyBack"}, cmd_ready, 1);
  endtask

  initial begin
    logic [7:0]  startTrace;
    logic [7:0]  readyTrace;
    logic [15:0] res0;
    logic [15:0] res1;
    logic        v0;
    logic        v1;
    logic        quietOk;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset:cmdReady", cmd_ready, 0);
    checkOutput("reset:aluStart", alu_start, 0);
    checkOutput("reset:rspValid", rsp_valid, 0);
    checkOutput("reset:rspResult", rsp_result, 0);
    checkOutput("reset:opCount", op_count, 0);
    reset_n = 1'b1;

    applyStimulus("addFF01", 3'b001, 8'hFF, 8'h01, 16'h0100, 8'd1, 1'b0, 1, 0);
    applyStimulus("mulFFFF", 3'b100, 8'hFF, 8'hFF, 16'hFE01, 8'd4, 1'b0, 4, 0);
    applyStimulus("mul0A0B", 3'b100, 8'h0A, 8'h0B, 16'h006E, 8'd4, 1'b0, 4, 0);

    // Back-to-back AND then XOR with cmd_valid held and rsp_ready high.
    checkOutput("b2b:readyAtStart", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    cmd_a     = 8'hF0;
    cmd_b     = 8'h3C;
    rsp_ready = 1'b1;
    res0 = 16'h0; res1 = 16'h0; v0 = 1'b0; v1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      startTrace[k] = alu_start;
      readyTrace[k] = cmd_ready;
      if (k == 0) cmd_op = 3'b011;
      if (k == 4) cmd_valid = 1'b0;
      if (k == 2) begin res0 = rsp_result; v0 = rsp_valid; end
      if (k == 6) begin res1 = rsp_result; v1 = rsp_valid; end
    end
    rsp_ready = 1'b0;
    expCount += 8'd2;
    checkOutput("b2b:startPattern", startTrace, 8'b0001_0001);
    checkOutput("b2b:readyPattern", readyTrace, 8'b1000_1000);
    checkOutput("b2b:andValid", v0, 1);
    checkOutput("b2b:andResult", res0, 16'h0030);
    checkOutput("b2b:xorValid", v1, 1);
    checkOutput("b2b:xorResult", res1, 16'h00CC);
    checkOutput("b2b:opCount", op_count, expCount);

    noDone = 1'b1;
    applyStimulus("timeout", 3'b001, 8'h07, 8'h09, 16'h0000, 8'd16, 1'b1, 16, 0);
    noDone = 1'b0;
    applyStimulus("add0203", 3'b001, 8'h02, 8'h03, 16'h0005, 8'd1, 1'b0, 1, 0);
    applyStimulus("mulStall", 3'b100, 8'h12, 8'h34, 16'h03A8, 8'd4, 1'b0, 4, 5);
    applyStimulus("nop", 3'b000, 8'h55, 8'hAA, 16'h0000, 8'd1, 1'b0, 1, 0);
    applyStimulus("mulOp7", 3'b111, 8'h03, 8'h05, 16'h000F, 8'd4, 1'b0, 4, 0);

    // Reset lands on the second RUN cycle of a multiply.
    cmd_valid = 1'b1;
    cmd_op    = 3'b100;
    cmd_a     = 8'h21;
    cmd_b     = 8'h43;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstMid:startBefore", alu_start, 1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rstMid:aluStart", alu_start, 0);
    checkOutput("rstMid:aluOp", alu_op, 0);
    checkOutput("rstMid:aluA", alu_a, 0);
    checkOutput("rstMid:aluB", alu_b, 0);
    checkOutput("rstMid:cmdReady", cmd_ready, 0);
    checkOutput("rstMid:rspValid", rsp_valid, 0);
    checkOutput("rstMid:rspLatency", rsp_latency, 0);
    checkOutput("rstMid:opCount", op_count, 0);
    reset_n = 1'b1;
    quietOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      quietOk &= (rsp_valid === 1'b0) && (alu_start === 1'b0);
    end
    checkOutput("rstMid:noResponse", quietOk, 1);
    checkOutput("rstMid:opCountAfter", op_count, 0);
    expCount = 8'd0;

    applyStimulus("add0101", 3'b001, 8'h01, 8'h01, 16'h0002, 8'd1, 1'b0, 1, 0);

    for (int n = 0; n < 254; n++) begin
      applyStimulus("fillNop", 3'b000, 8'h00, 8'h00, 16'h0000, 8'd1, 1'b0, 1, 0);
    end
    checkOutput("wrap:preload", op_count, 8'hFF);
    applyStimulus("wrapNop", 3'b000, 8'h00, 8'h00, 16'h0000, 8'd1, 1'b0, 1, 0);
    checkOutput("wrap:zero", op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #300000;
    failCount++;
    $display("[TB] FAIL globalTimeout observed=expired expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
